// File: rtl/afe_thr_stream_arbiter.sv
// Round-robin arbiter draining per-stream FIFOs onto one threshold-unit lane.
// Optional per-stream drop counters: define AFE_THR_ARB_DROP_CNT_EN.

module afe_thr_stream_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int W_GAP      = 4,
  parameter int W_SRC      = 3
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_en_i,
  input  logic [W_GAP-1:0]      cfg_gap_i,
  input  logic [NUM_REQ-1:0]    cfg_prio_mask_i,
  input  logic                  ovf_clr_i,
  input  logic [NUM_REQ-1:0]    req_vld_i,
  input  logic [NUM_REQ*32-1:0] req_data_i,
  output logic                  out_vld_o,
  output logic [31:0]           out_data_o,
  output logic [W_SRC-1:0]      out_src_o,
  output logic [NUM_REQ-1:0]    ovf_o,
  output logic                  busy_o,
  output logic [NUM_REQ*16-1:0] drop_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W_GAP-1:0]   gap_cnt;
  logic [W_SRC-1:0]   rr_ptr;
  logic [W_SRC-1:0]   gnt_idx;
  logic [W_SRC-1:0]   hi_idx;
  logic [W_SRC-1:0]   lo_idx;
  logic               hi_hit;
  logic [NUM_REQ-1:0] empty;
  logic [NUM_REQ-1:0] full;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] drop;
  logic [31:0]        head [NUM_REQ];
  logic [31:0]        data_q;
  logic [W_SRC-1:0]   src_q;
  logic [NUM_REQ-1:0] ovf_q;
  logic               can_arb;
  logic               grant;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    logic [AW:0] wp;
    logic [AW:0] rp;
    logic [31:0] mem [FIFO_DEPTH];

    assign empty[g] = (wp == rp);
    assign full[g]  = (wp[AW] != rp[AW]) &&
                      (wp[AW-1:0] == rp[AW-1:0]);
    assign push[g]  = cfg_en_i && req_vld_i[g];
    assign pop[g]   = grant && (gnt_idx == W_SRC'(g));
    // a pop frees the head slot at the same edge, so a full push survives
    assign drop[g]  = push[g] && full[g] && !pop[g];
    assign head[g]  = mem[rp[AW-1:0]];

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        wp <= '0;
        rp <= '0;
      end else if (!cfg_en_i) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push[g] && !drop[g])
          wp <= wp + 1'b1;
        if (pop[g])
          rp <= rp + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (push[g] && !drop[g])
        mem[wp[AW-1:0]] <= req_data_i[g*32 +: 32];
    end

`ifdef AFE_THR_ARB_DROP_CNT_EN
    logic [15:0] dcnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
        dcnt <= '0;
      else if (drop[g])
        dcnt <= ovf_clr_i ? 16'd1 :
                (dcnt == 16'hFFFF) ? dcnt : dcnt + 16'd1;
      else if (ovf_clr_i)
        dcnt <= '0;
    end

    assign drop_cnt_o[g*16 +: 16] = dcnt;
`else
    assign drop_cnt_o[g*16 +: 16] = 16'd0;
`endif
  end

  assign elig = ~empty & ~cfg_prio_mask_i;

  // lowest eligible at/above the pointer, else lowest eligible overall
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_hit = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i])
        lo_idx = W_SRC'(i);
      if (elig[i] && (W_SRC'(i) >= rr_ptr)) begin
        hi_idx = W_SRC'(i);
        hi_hit = 1'b1;
      end
    end
    gnt_idx = hi_hit ? hi_idx : lo_idx;
  end

  always_comb begin
    can_arb = 1'b0;
    unique case (state)
      IDLE:    can_arb = 1'b1;
      ISSUE:   can_arb = (cfg_gap_i == '0);
      GAP:     can_arb = (gap_cnt == '0);
      default: can_arb = 1'b0;
    endcase
  end

  assign grant = cfg_en_i && can_arb && (|elig);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!cfg_en_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant)
            state_nxt = ISSUE;
        end
        ISSUE: begin
          if (cfg_gap_i != '0)
            state_nxt = GAP;
          else
            state_nxt = grant ? ISSUE : IDLE;
        end
        GAP: begin
          if (gap_cnt == '0)
            state_nxt = grant ? ISSUE : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    out_vld_o = (state == ISSUE);
    busy_o    = (~&empty) || (state != IDLE);
  end

  // counter reaches zero on the last idle cycle, where the next grant issues
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      gap_cnt <= '0;
    else if (!cfg_en_i)
      gap_cnt <= '0;
    else if (state == ISSUE && cfg_gap_i != '0)
      gap_cnt <= cfg_gap_i - 1'b1;
    else if (state == GAP && gap_cnt != '0)
      gap_cnt <= gap_cnt - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q <= '0;
      src_q  <= '0;
      rr_ptr <= '0;
    end else if (grant) begin
      data_q <= head[gnt_idx];
      src_q  <= gnt_idx;
      rr_ptr <= (gnt_idx == W_SRC'(NUM_REQ - 1)) ?
                '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      ovf_q <= '0;
    else
      ovf_q <= (ovf_clr_i ? '0 : ovf_q) | drop;
  end

  assign out_data_o = data_q;
  assign out_src_o  = src_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_afe_thr_stream_arbiter.sv
// Directed bench for afe_thr_stream_arbiter: vector table plus
// hand sequences for fairness, pacing, overflow, disable and reset.

module tb_afe_thr_stream_arbiter;

  logic         clk = 1'b0;
  logic         rstn;
  logic         en;
  logic [3:0]   gap;
  logic [3:0]   mask;
  logic         clr;
  logic [3:0]   vld;
  logic [127:0] data;
  logic         out_vld;
  logic [31:0]  out_data;
  logic [2:0]   out_src;
  logic [3:0]   ovf;
  logic         busy;
  logic [63:0]  drop_cnt;

  int passed = 0;
  int total  = 0;

  afe_thr_stream_arbiter #(
    .NUM_REQ(4),
    .FIFO_DEPTH(4),
    .W_GAP(4),
    .W_SRC(3)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .cfg_en_i(en),
    .cfg_gap_i(gap),
    .cfg_prio_mask_i(mask),
    .ovf_clr_i(clr),
    .req_vld_i(vld),
    .req_data_i(data),
    .out_vld_o(out_vld),
    .out_data_o(out_data),
    .out_src_o(out_src),
    .ovf_o(ovf),
    .busy_o(busy),
    .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          src;
    logic [31:0] d;
    logic [3:0]  gap;
    logic [3:0]  mask;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  es;
  } vec_t;

  vec_t tbl [5];
  int   cnt;
  logic [63:0] exp_drop;

  initial begin
    tbl[0] = '{2, 32'h1000_00AB, 4'd0,  4'b0000, 1'b1, 32'h1000_00AB, 3'd2};
    tbl[1] = '{0, 32'hDEAD_BEEF, 4'd3,  4'b0000, 1'b1, 32'hDEAD_BEEF, 3'd0};
    tbl[2] = '{3, 32'h0000_0001, 4'd0,  4'b0111, 1'b1, 32'h0000_0001, 3'd3};
    tbl[3] = '{1, 32'h1234_5678, 4'd0,  4'b0010, 1'b0, 32'h0000_0001, 3'd3};
    tbl[4] = '{3, 32'hFFFF_FFFF, 4'd15, 4'b0000, 1'b1, 32'hFFFF_FFFF, 3'd3};

    rstn = 1'b0; en = 1'b1; gap = '0; mask = '0;
    clr = 1'b0; vld = '0; data = '0;
    #1;
    chk("rst_vld", out_vld, 0);
    tick; tick;
    chk("rst_data", out_data, 0);
    chk("rst_src", out_src, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    rstn = 1'b1;
    tick;

    // single-sample vectors: push in cycle N, strobe in N+2 only
    for (int v = 0; v < 5; v++) begin
      gap  = tbl[v].gap;
      mask = tbl[v].mask;
      vld  = '0;
      vld[tbl[v].src] = 1'b1;
      data[tbl[v].src*32 +: 32] = tbl[v].d;
      tick;
      vld = '0;
      chk("vec_n1_vld", out_vld, 0);
      tick;
      chk("vec_vld", out_vld, tbl[v].ev);
      chk("vec_data", out_data, tbl[v].ed);
      chk("vec_src", out_src, tbl[v].es);
      tick;
      chk("vec_n3_vld", out_vld, 0);
      en = 1'b0;
      tick;
      en = 1'b1; mask = '0;
      tick;
      chk("vec_flush_busy", busy, 0);
    end

    rstn = 1'b0; tick; rstn = 1'b1; tick;

    // fairness: 4 streams x 3 samples -> 0,1,2,3 x3 on consecutive cycles
    gap = 4'd0;
    for (int t = 0; t < 15; t++) begin
      vld = (t < 3) ? 4'hF : 4'h0;
      for (int i = 0; i < 4; i++)
        data[i*32 +: 32] = 32'hA000_0000 + 32'(t * 256 + i);
      tick;
      if (t >= 1 && t <= 12) begin
        chk("fair_vld", out_vld, 1);
        chk("fair_src", out_src, 64'((t - 1) % 4));
        chk("fair_data", out_data,
            64'(32'hA000_0000 + 32'(((t - 1) / 4) * 256 + (t - 1) % 4)));
      end else begin
        chk("fair_idle", out_vld, 0);
      end
    end
    chk("fair_busy_end", busy, 0);

    // gap pacing: gap 3 -> strobes at cycles 2,6,10,14; busy low at 18
    gap = 4'd3;
    for (int t = 0; t < 20; t++) begin
      vld = (t < 4) ? 4'b0010 : 4'b0000;
      data[32 +: 32] = 32'hB000_0000 + 32'(t);
      tick;
      if ((t + 1) >= 2 && ((t - 1) % 4) == 0 && ((t - 1) / 4) < 4) begin
        chk("gap_vld", out_vld, 1);
        chk("gap_data", out_data, 64'(32'hB000_0000 + 32'((t - 1) / 4)));
      end else begin
        chk("gap_idle", out_vld, 0);
      end
      chk("gap_busy", busy, (t + 1) <= 17 ? 64'd1 : 64'd0);
    end

    // overflow: 6 pushes into masked req 1 -> 4 kept, 2 dropped
    gap = 4'd0;
    mask = 4'b0010;
    for (int t = 0; t < 6; t++) begin
      vld = 4'b0010;
      data[32 +: 32] = 32'hC000_0000 + 32'(t);
      tick;
      if (t == 3)
        chk("ovf_not_yet", ovf, 0);
    end
    vld = '0;
`ifdef AFE_THR_ARB_DROP_CNT_EN
    exp_drop = 64'h0000_0000_0002_0000;
`else
    exp_drop = 64'h0;
`endif
    chk("ovf_set", ovf, 4'b0010);
    chk("ovf_masked_vld", out_vld, 0);
    chk("ovf_busy", busy, 1);
    chk("ovf_drop_cnt", drop_cnt, exp_drop);
    mask = '0;
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      tick;
      if (out_vld === 1'b1) begin
        chk("ovf_data", out_data, 64'(32'hC000_0000 + 32'(cnt)));
        cnt++;
      end
    end
    chk("ovf_strobes", cnt, 4);
    chk("ovf_sticky", ovf, 4'b0010);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    chk("ovf_clr_drop", drop_cnt, 0);

    // full FIFO: pop and push in the same cycle must not drop
    mask = 4'b0001;
    for (int t = 0; t < 4; t++) begin
      vld = 4'b0001;
      data[0 +: 32] = 32'hD000_0000 + 32'(t);
      tick;
    end
    mask = '0;
    vld = 4'b0001;
    data[0 +: 32] = 32'hD000_0004;
    tick;
    vld = '0;
    mask = 4'b0001;
    chk("full_vld", out_vld, 1);
    chk("full_data", out_data, 32'hD000_0000);
    chk("full_ovf", ovf, 0);
    mask = '0;
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      tick;
      if (out_vld === 1'b1) begin
        chk("full_drain", out_data, 64'(32'hD000_0001 + 32'(cnt)));
        cnt++;
      end
    end
    chk("full_strobes", cnt, 4);
    chk("full_ovf_end", ovf, 0);

    // disable mid-stream: one trailing strobe then silence
    mask = 4'hF;
    for (int t = 0; t < 2; t++) begin
      vld = 4'hF;
      for (int i = 0; i < 4; i++)
        data[i*32 +: 32] = 32'hE000_0000 + 32'(t * 16 + i);
      tick;
    end
    vld = '0;
    mask = '0;
    tick;
    chk("dis_trailing", out_vld, 1);
    en = 1'b0;
    vld = 4'hF;
    tick;
    en = 1'b1;
    vld = '0;
    chk("dis_busy", busy, 0);
    chk("dis_vld", out_vld, 0);
    cnt = 0;
    for (int t = 0; t < 6; t++) begin
      tick;
      if (out_vld === 1'b1)
        cnt++;
    end
    chk("dis_silent", cnt, 0);

    // asynchronous reset mid-stream
    mask = 4'b0100;
    for (int t = 0; t < 5; t++) begin
      vld = 4'b0101;
      data[0 +: 32]  = 32'hF000_0000 + 32'(t);
      data[64 +: 32] = 32'hF100_0000 + 32'(t);
      tick;
    end
    vld = '0;
    chk("ar_pre_vld", out_vld, 1);
    chk("ar_pre_ovf", ovf, 4'b0100);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_vld", out_vld, 0);
    chk("ar_data", out_data, 0);
    chk("ar_src", out_src, 0);
    chk("ar_ovf", ovf, 0);
    chk("ar_busy", busy, 0);
    chk("ar_drop", drop_cnt, 0);
    tick;
    rstn = 1'b1;
    mask = '0;
    tick;
    chk("ar_post_vld", out_vld, 0);
    chk("ar_post_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
